uart_boot_loader: RTL and testbench

CPU-side end of the UART boot protocol: after reset it sends a hello byte, receives a 4-byte little-endian program size, then receives the program bytes and writes them as 32-bit little-endian words into instruction memory from word address 0. When the program is complete it sends an acknowledge byte and asserts `done`, which releases the core and hands the UART to the running program. It sits between the `UartRx`/`UartTx` byte interfaces and the instruction-memory write port inside `top`.

---
 rtl/boot_pkg.sv | 17 +
 rtl/uart_boot_loader_if.sv | 25 ++
 rtl/byte_packer.sv | 40 ++++
 rtl/uart_boot_loader.sv | 134 +++++++++++++
 tb/tb_uart_boot_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the UART boot loader.
// The byte values are also used by the host-side simulation server.
package boot_pkg;

    typedef enum logic [2:0] {
        S_HELLO,
        S_SIZE,
        S_PROG,
        S_ACK,
        S_DONE
    } boot_state_t;

    localparam logic [7:0] BOOT_HELLO      = 8'h99;
    localparam logic [7:0] BOOT_ACK        = 8'haa;
    localparam int         BOOT_SIZE_BYTES = 4;

endpackage

// File: rtl/uart_boot_loader_if.sv
// UART byte interface and instruction-memory write port of the boot loader.
// master = the loader, slave = the UART/memory side.
interface uart_boot_loader_if #(
    parameter int IMEM_ADDR_WIDTH = 14
);
    logic                       rx_ready;
    logic [7:0]                 rdata;
    logic                       ferr;
    logic                       tx_busy;
    logic                       tx_start;
    logic [7:0]                 sdata;
    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_wd;

    modport master (
        input  rx_ready, rdata, ferr, tx_busy,
        output tx_start, sdata, imem_we, imem_addr, imem_wd
    );

    modport slave (
        output rx_ready, rdata, ferr, tx_busy,
        input  tx_start, sdata, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/byte_packer.sv
// Little-endian 8->32 assembler; word/word_valid are presented in the cycle
// the completing byte arrives, so the caller can register them directly.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        flush,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [31:0] buf_q;
    logic [1:0]  lane_q;

    assign lane = lane_q;

    always_comb begin
        word = buf_q;
        if (in_valid)
            word[{lane_q, 3'b000} +: 8] = in_byte;
        word_valid = in_valid && ((lane_q == 2'd3) || flush);
    end

    // Buffer is cleared after every word, so a flushed word is zero-padded.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q  <= '0;
            lane_q <= '0;
        end else if (in_valid) begin
            if (word_valid) begin
                buf_q  <= '0;
                lane_q <= '0;
            end else begin
                buf_q  <= word;
                lane_q <= lane_q + 2'd1;
            end
        end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// CPU-side UART boot loader: hello, 4-byte size, program words into imem,
// then ack and release the core via done.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int         IMEM_ADDR_WIDTH = 14,
    parameter logic [7:0] HELLO_BYTE      = BOOT_HELLO,
    parameter logic [7:0] ACK_BYTE        = BOOT_ACK
) (
    input  logic                clock,
    input  logic                reset,
    uart_boot_loader_if.master  bus,
    output logic                done,
    output logic                overflow,
    output logic                rx_error
);
    boot_state_t                state;
    logic [31:0]                size_q;
    logic [31:0]                byte_cnt;
    logic [IMEM_ADDR_WIDTH-1:0] word_addr;
    logic                       addr_full;

    logic        accept;
    logic        last;
    logic [1:0]  pk_lane;
    logic [31:0] pk_word;
    logic        pk_valid;
    logic        size_done;

    assign accept = bus.rx_ready &&
                    (state == S_SIZE || state == S_PROG);
    assign last = (state == S_PROG) &&
                  (byte_cnt + 32'd1 == size_q);
    assign size_done = pk_valid &&
                       (pk_lane == 2'(BOOT_SIZE_BYTES - 1));

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (accept),
        .in_byte    (bus.rdata),
        .flush      (last),
        .lane       (pk_lane),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_HELLO;
            size_q        <= '0;
            byte_cnt      <= '0;
            word_addr     <= '0;
            addr_full     <= 1'b0;
            bus.tx_start  <= 1'b0;
            bus.sdata     <= '0;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_wd   <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.imem_we  <= 1'b0;
            if (accept && bus.ferr)
                rx_error <= 1'b1;
            unique case (state)
                S_HELLO: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.sdata    <= HELLO_BYTE;
                        state        <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (size_done) begin
                        size_q <= pk_word;
                        if (pk_word != '0) begin
                            state <= S_PROG;
                        end else if (!bus.tx_busy) begin
                            bus.tx_start <= 1'b1;
                            bus.sdata    <= ACK_BYTE;
                            state        <= S_DONE;
                        end else begin
                            state <= S_ACK;
                        end
                    end
                end
                S_PROG: begin
                    if (bus.rx_ready) begin
                        byte_cnt <= byte_cnt + 32'd1;
                        // Past the last word, bytes are counted but not written.
                        if (pk_valid) begin
                            if (addr_full) begin
                                overflow <= 1'b1;
                            end else begin
                                bus.imem_we   <= 1'b1;
                                bus.imem_addr <= word_addr;
                                bus.imem_wd   <= pk_word;
                                if (&word_addr)
                                    addr_full <= 1'b1;
                                else
                                    word_addr <= word_addr + 1'b1;
                            end
                        end
                        if (last) begin
                            if (!bus.tx_busy) begin
                                bus.tx_start <= 1'b1;
                                bus.sdata    <= ACK_BYTE;
                                state        <= S_DONE;
                            end else begin
                                state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.sdata    <= ACK_BYTE;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_HELLO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader with a 4-word instruction memory.
// Stimulus pushes expected TX bytes and writes; a negedge monitor pops them.
module tb_uart_boot_loader;
    localparam int AW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic done;
    logic overflow;
    logic rx_error;

    uart_boot_loader_if #(.IMEM_ADDR_WIDTH(AW)) bif ();

    uart_boot_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bif),
        .done     (done),
        .overflow (overflow),
        .rx_error (rx_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int last_tx_cyc = -1;
    int last_we_cyc = -2;
    logic tx_prev = 1'b0;
    logic done_prev = 1'b0;

    logic [7:0]    exp_tx[$];
    logic [AW+31:0] exp_wr[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compares every DUT transmit and memory write in order.
    always @(negedge clock) begin
        if (!reset) begin
            if (bif.tx_start) begin
                check("tx_width", {63'd0, tx_prev}, 64'd0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h required=none",
                             bif.sdata);
                end else begin
                    check("tx_byte", {56'd0, bif.sdata},
                          {56'd0, exp_tx.pop_front()});
                end
                last_tx_cyc = cyc;
            end
            if (bif.imem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=%0h@%0h required=none",
                             bif.imem_wd, bif.imem_addr);
                end else begin
                    check("imem_write", {30'd0, bif.imem_addr, bif.imem_wd},
                          {30'd0, exp_wr.pop_front()});
                end
                last_we_cyc = cyc;
            end
            if (done && !done_prev)
                check("done_delay", 64'(cyc - last_tx_cyc), 64'd1);
        end
        tx_prev   = bif.tx_start;
        done_prev = done;
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic do_reset(input bit push_hello);
        @(negedge clock);
        reset = 1'b1;
        bif.rx_ready = 1'b0;
        bif.ferr = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_tx_start", {63'd0, bif.tx_start}, 64'd0);
        check("rst_sdata", {56'd0, bif.sdata}, 64'd0);
        check("rst_imem_we", {63'd0, bif.imem_we}, 64'd0);
        check("rst_imem_addr", {62'd0, bif.imem_addr}, 64'd0);
        check("rst_imem_wd", {32'd0, bif.imem_wd}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_rx_error", {63'd0, rx_error}, 64'd0);
        exp_tx.delete();
        exp_wr.delete();
        if (push_hello)
            exp_tx.push_back(8'h99);
        reset = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bs[$], input int gap,
                            input int fe_at);
        foreach (bs[i]) begin
            @(negedge clock);
            bif.rx_ready = 1'b1;
            bif.rdata    = bs[i];
            bif.ferr     = (i == fe_at);
            rx_cyc       = cyc + 1;
            repeat (gap) begin
                @(negedge clock);
                bif.rx_ready = 1'b0;
                bif.ferr     = 1'b0;
            end
        end
        @(negedge clock);
        bif.rx_ready = 1'b0;
        bif.ferr     = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || !done) &&
               n < bound) begin
            @(negedge clock);
            n++;
        end
        check(name, {63'd0, n < bound}, 64'd1);
        @(negedge clock);
    endtask

    task automatic check_flags(input logic ov, input logic re);
        check("done", {63'd0, done}, 64'd1);
        check("overflow", {63'd0, overflow}, {63'd0, ov});
        check("rx_error", {63'd0, rx_error}, {63'd0, re});
    endtask

    initial begin
        logic [7:0] bs[$];
        bif.rx_ready = 1'b0;
        bif.rdata    = 8'h00;
        bif.ferr     = 1'b0;
        bif.tx_busy  = 1'b0;

        // Clean load, all bytes back to back.
        do_reset(1'b1);
        push_wr(2'd0, 32'h04030201);
        push_wr(2'd1, 32'hddccbbaa);
        exp_tx.push_back(8'haa);
        send_seq('{8'h08, 8'h00, 8'h00, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04,
                   8'haa, 8'hbb, 8'hcc, 8'hdd}, 0, -1);
        wait_drain("clean_timeout", 100);
        check_flags(1'b0, 1'b0);
        check("ack_with_write", 64'(last_tx_cyc), 64'(last_we_cyc));
        check("ack_latency", 64'(last_tx_cyc), 64'(rx_cyc));
        send_seq('{8'h55}, 0, -1);
        repeat (5) @(negedge clock);
        check("done_sticky", {63'd0, done}, 64'd1);

        // Partial final word; ack held off by a busy transmitter.
        do_reset(1'b1);
        push_wr(2'd0, 32'h44332211);
        push_wr(2'd1, 32'h00000055);
        exp_tx.push_back(8'haa);
        send_seq('{8'h05, 8'h00, 8'h00, 8'h00,
                   8'h11, 8'h22, 8'h33, 8'h44}, 2, -1);
        bif.tx_busy = 1'b1;
        send_seq('{8'h55}, 0, -1);
        repeat (5) @(negedge clock);
        check("ack_waits_busy", 64'(exp_tx.size()), 64'd1);
        bif.tx_busy = 1'b0;
        wait_drain("partial_timeout", 100);
        check_flags(1'b0, 1'b0);

        // Zero size: ack directly after the size field.
        do_reset(1'b1);
        exp_tx.push_back(8'haa);
        send_seq('{8'h00, 8'h00, 8'h00, 8'h00}, 1, -1);
        wait_drain("zero_timeout", 100);
        check_flags(1'b0, 1'b0);
        check("zero_ack_latency", 64'(last_tx_cyc), 64'(rx_cyc));

        // Overflow: 20 bytes into a 4-word memory.
        do_reset(1'b1);
        bs = '{8'h14, 8'h00, 8'h00, 8'h00};
        for (int i = 1; i <= 20; i++)
            bs.push_back(8'(i));
        for (int n = 0; n < 4; n++)
            push_wr(AW'(n), {8'(4*n+4), 8'(4*n+3), 8'(4*n+2), 8'(4*n+1)});
        exp_tx.push_back(8'haa);
        send_seq(bs, 0, -1);
        wait_drain("overflow_timeout", 100);
        check_flags(1'b1, 1'b0);

        // Hello held by busy transmitter, stray byte ignored.
        bif.tx_busy = 1'b1;
        do_reset(1'b0);
        send_seq('{8'h77}, 0, -1);
        repeat (50) @(negedge clock);
        exp_tx.push_back(8'h99);
        bif.tx_busy = 1'b0;
        repeat (3) @(negedge clock);
        check("hello_sent", 64'(exp_tx.size()), 64'd0);

        // Framing error then reset after 3 program bytes.
        send_seq('{8'h08, 8'h00, 8'h00, 8'h00,
                   8'h01, 8'h02, 8'h03}, 0, 6);
        repeat (3) @(negedge clock);
        check("ferr_sticky", {63'd0, rx_error}, 64'd1);
        check("midload_not_done", {63'd0, done}, 64'd0);
        do_reset(1'b1);

        // Full reload restarts at address 0; ferr byte still stored.
        push_wr(2'd0, 32'h04030201);
        push_wr(2'd1, 32'hddccbbaa);
        exp_tx.push_back(8'haa);
        send_seq('{8'h08, 8'h00, 8'h00, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04,
                   8'haa, 8'hbb, 8'hcc, 8'hdd}, 1, 5);
        wait_drain("reload_timeout", 100);
        check_flags(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
